// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the multi-digit up/down counter.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_nibble_t;

  // Out-of-range load nibbles (A..F) are pinned to 9 so Q only ever holds BCD.
  function automatic bcd_nibble_t bcd_clamp(input bcd_nibble_t nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter: load, increment with carry-out wrap, decrement with borrow wrap.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic [BCD_W-1:0] rst_val,
  input  logic             load,
  input  logic [BCD_W-1:0] din,
  input  logic             inc,
  input  logic             dec,
  input  logic             hold,
  output logic [BCD_W-1:0] q,
  output logic             is_max,
  output logic             is_min
);

  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] q_q;

  // Load beats counting; hold freezes the digit at a saturated boundary.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_clamp(din);
    end else if (!hold) begin
      if (inc) begin
        q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else if (dec) begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign is_max = (q_q == BCD_MAX);
  assign is_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, terminal count, zero flag and wrap/saturate boundary event.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int                      DIGITS  = 2,
  parameter int                      WRAP    = 1,
  parameter logic [BCD_W*DIGITS-1:0] RST_BCD = '0
)(
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      En,
  input  logic                      Up,
  input  logic                      Load,
  input  logic [BCD_W*DIGITS-1:0]   Din,
  output logic [BCD_W*DIGITS-1:0]   Q,
  output logic                      Tc,
  output logic                      Zero,
  output logic                      Evt
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  logic              hold;
  logic              evt_d;
  logic              evt_q;

  // Each digit steps only when every lower digit sits at its carry/borrow value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [DIGITS-1:0] LOW_MASK = DIGITS'((1 << g) - 1);

    assign inc[g] = En &  Up & (&(is_max | ~LOW_MASK));
    assign dec[g] = En & ~Up & (&(is_min | ~LOW_MASK));

    bcd_digit u_digit (
      .Clk     (Clk),
      .Rst     (Rst),
      .rst_val (RST_BCD[BCD_W*g +: BCD_W]),
      .load    (Load),
      .din     (Din[BCD_W*g +: BCD_W]),
      .inc     (inc[g]),
      .dec     (dec[g]),
      .hold    (hold),
      .q       (Q[BCD_W*g +: BCD_W]),
      .is_max  (is_max[g]),
      .is_min  (is_min[g])
    );
  end

  assign Tc    = Up ? (&is_max) : (&is_min);
  assign Zero  = &is_min;
  assign hold  = ~WRAP_EN & Tc;
  assign evt_d = ~Load & En & Tc;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign Evt = evt_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scenario bench for bcd_updown_counter: directed cases plus a randomized run against an integer model.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-digit wrapping counter, reset value 25
  logic w_rst, w_en, w_up, w_load, w_tc, w_zero, w_evt;
  logic [7:0] w_din, w_q;
  // Two-digit saturating counter, reset value 25
  logic s_rst, s_en, s_up, s_load, s_tc, s_zero, s_evt;
  logic [7:0] s_din, s_q;
  // Four-digit wrapping counter, reset value 0
  logic f_rst, f_en, f_up, f_load, f_tc, f_zero, f_evt;
  logic [15:0] f_din, f_q;

  int check_cnt = 0;
  int pass_cnt  = 0;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1), .RST_BCD(8'h25)) dut_w (
    .Clk(clk), .Rst(w_rst), .En(w_en), .Up(w_up), .Load(w_load), .Din(w_din),
    .Q(w_q), .Tc(w_tc), .Zero(w_zero), .Evt(w_evt));

  bcd_updown_counter #(.DIGITS(2), .WRAP(0), .RST_BCD(8'h25)) dut_s (
    .Clk(clk), .Rst(s_rst), .En(s_en), .Up(s_up), .Load(s_load), .Din(s_din),
    .Q(s_q), .Tc(s_tc), .Zero(s_zero), .Evt(s_evt));

  bcd_updown_counter #(.DIGITS(4), .WRAP(1), .RST_BCD(16'h0000)) dut_f (
    .Clk(clk), .Rst(f_rst), .En(f_en), .Up(f_up), .Load(f_load), .Din(f_din),
    .Q(f_q), .Tc(f_tc), .Zero(f_zero), .Evt(f_evt));

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp_din(input logic [15:0] b, input int digits);
    int v = 0;
    int nib;
    for (int i = digits - 1; i >= 0; i--) begin
      nib = int'(b[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v, input int digits);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic valid_bcd(input logic [15:0] b, input int digits);
    for (int i = 0; i < digits; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_next(input int v, input int digits, input logic wrap, input logic rst,
                                    input int rstv, input logic load, input int din_v,
                                    input logic en, input logic up);
    int mx = pow10(digits) - 1;
    if (rst)  return rstv;
    if (load) return din_v;
    if (!en)  return v;
    if (up)   return (v == mx) ? (wrap ? 0 : v) : v + 1;
    return (v == 0) ? (wrap ? mx : 0) : v - 1;
  endfunction

  function automatic logic model_evt(input int v, input int digits, input logic rst,
                                     input logic load, input logic en, input logic up);
    int mx = pow10(digits) - 1;
    return !rst && !load && en && (up ? (v == mx) : (v == 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_seq [3] = '{8'h24, 8'h23, 8'h22};
    w_rst = 1; s_rst = 1; f_rst = 1;
    w_en = 1; w_up = 1;
    tick();
    check_cnt++; if (w_q !== 8'h25) $display("[TB] FAIL reset_w_q got %h want 25", w_q); else pass_cnt++;
    check_cnt++; if (w_evt !== 1'b0) $display("[TB] FAIL reset_w_evt got %b want 0", w_evt); else pass_cnt++;
    check_cnt++; if (s_q !== 8'h25) $display("[TB] FAIL reset_s_q got %h want 25", s_q); else pass_cnt++;
    check_cnt++; if (f_q !== 16'h0000 || f_zero !== 1'b1) $display("[TB] FAIL reset_f got q=%h zero=%b want 0000/1", f_q, f_zero); else pass_cnt++;
    w_rst = 0; s_rst = 0; f_rst = 0;
    w_up = 0; w_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if (w_q !== exp_seq[i]) $display("[TB] FAIL reset_down%0d got %h want %h", i, w_q, exp_seq[i]); else pass_cnt++;
    end
    w_en = 0;
  endtask

  task automatic test_borrow_wrap();
    w_load = 1; w_din = 8'h10; w_en = 0; w_up = 0;
    tick();
    w_load = 0; w_en = 1;
    tick();
    check_cnt++; if (w_q !== 8'h09) $display("[TB] FAIL borrow got %h want 09", w_q); else pass_cnt++;
    repeat (9) tick();
    check_cnt++; if (w_q !== 8'h00 || w_tc !== 1'b1 || w_zero !== 1'b1)
      $display("[TB] FAIL down_to_zero got q=%h tc=%b zero=%b want 00/1/1", w_q, w_tc, w_zero); else pass_cnt++;
    tick();
    check_cnt++; if (w_q !== 8'h99 || w_evt !== 1'b1) $display("[TB] FAIL wrap_down got q=%h evt=%b want 99/1", w_q, w_evt); else pass_cnt++;
    tick();
    check_cnt++; if (w_q !== 8'h98 || w_evt !== 1'b0) $display("[TB] FAIL after_wrap got q=%h evt=%b want 98/0", w_q, w_evt); else pass_cnt++;
    w_en = 0;
  endtask

  task automatic test_saturate();
    logic exp_evt [3] = '{1'b0, 1'b1, 1'b1};
    s_load = 1; s_din = 8'h98; s_en = 0; s_up = 1;
    tick();
    s_load = 0; s_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if (s_q !== 8'h99 || s_evt !== exp_evt[i] || s_tc !== 1'b1)
        $display("[TB] FAIL sat_up%0d got q=%h evt=%b tc=%b want 99/%b/1", i, s_q, s_evt, s_tc, exp_evt[i]); else pass_cnt++;
    end
    s_up = 0;
    tick();
    check_cnt++; if (s_q !== 8'h98 || s_evt !== 1'b0) $display("[TB] FAIL sat_reverse got q=%h evt=%b want 98/0", s_q, s_evt); else pass_cnt++;
    s_load = 1; s_din = 8'h01; s_en = 0;
    tick();
    s_load = 0; s_en = 1;
    tick();
    tick();
    check_cnt++; if (s_q !== 8'h00 || s_evt !== 1'b1 || s_zero !== 1'b1)
      $display("[TB] FAIL sat_down got q=%h evt=%b zero=%b want 00/1/1", s_q, s_evt, s_zero); else pass_cnt++;
    s_en = 0;
  endtask

  task automatic test_load_priority();
    w_load = 1; w_din = 8'hAF; w_en = 0;
    tick();
    check_cnt++; if (w_q !== 8'h99) $display("[TB] FAIL load_clamp got %h want 99", w_q); else pass_cnt++;
    w_din = 8'h42; w_en = 1; w_up = 1;
    tick();
    check_cnt++; if (w_q !== 8'h42 || w_evt !== 1'b0) $display("[TB] FAIL load_with_en got q=%h evt=%b want 42/0", w_q, w_evt); else pass_cnt++;
    w_load = 0; w_en = 0;
  endtask

  task automatic test_reset_mid_count();
    w_load = 1; w_din = 8'h57;
    tick();
    w_load = 0; w_en = 1; w_up = 1;
    tick();
    check_cnt++; if (w_q !== 8'h58) $display("[TB] FAIL pre_reset got %h want 58", w_q); else pass_cnt++;
    w_rst = 1;
    tick();
    check_cnt++; if (w_q !== 8'h25 || w_evt !== 1'b0) $display("[TB] FAIL mid_reset got q=%h evt=%b want 25/0", w_q, w_evt); else pass_cnt++;
    w_rst = 0; w_load = 1; w_din = 8'h40;
    tick();
    w_load = 0; w_up = 0;
    tick();
    check_cnt++; if (w_q !== 8'h39) $display("[TB] FAIL reverse_down got %h want 39", w_q); else pass_cnt++;
    w_up = 1;
    tick();
    check_cnt++; if (w_q !== 8'h40) $display("[TB] FAIL reverse_up got %h want 40", w_q); else pass_cnt++;
    w_en = 0;
  endtask

  task automatic test_four_digit();
    f_load = 1; f_din = 16'h0999; f_en = 0; f_up = 1;
    tick();
    f_load = 0; f_en = 1;
    tick();
    check_cnt++; if (f_q !== 16'h1000 || f_evt !== 1'b0) $display("[TB] FAIL carry3 got q=%h evt=%b want 1000/0", f_q, f_evt); else pass_cnt++;
    f_load = 1; f_din = 16'h9999; f_en = 0;
    tick();
    check_cnt++; if (f_tc !== 1'b1) $display("[TB] FAIL tc_9999 got %b want 1", f_tc); else pass_cnt++;
    f_load = 0; f_en = 1;
    tick();
    check_cnt++; if (f_q !== 16'h0000 || f_evt !== 1'b1 || f_zero !== 1'b1)
      $display("[TB] FAIL wrap4_up got q=%h evt=%b zero=%b want 0000/1/1", f_q, f_evt, f_zero); else pass_cnt++;
    f_up = 0;
    tick();
    check_cnt++; if (f_q !== 16'h9999 || f_evt !== 1'b1) $display("[TB] FAIL wrap4_down got q=%h evt=%b want 9999/1", f_q, f_evt); else pass_cnt++;
    f_en = 0;
  endtask

  task automatic test_random(input int n);
    int mw = 0, ms = 0, mf = 0;
    logic ew, es, ef;
    logic [15:0] exp;
    for (int k = 0; k < n; k++) begin
      w_rst = (k == 0) || ($urandom_range(31) == 0);
      w_load = ($urandom_range(7) == 0); w_en = ($urandom_range(3) != 0);
      w_up = 1'($urandom_range(1)); w_din = 8'($urandom);
      s_rst = (k == 0) || ($urandom_range(31) == 0);
      s_load = ($urandom_range(7) == 0); s_en = ($urandom_range(3) != 0);
      s_up = 1'($urandom_range(1)); s_din = 8'($urandom);
      f_rst = (k == 0) || ($urandom_range(31) == 0);
      f_load = ($urandom_range(7) == 0); f_en = ($urandom_range(3) != 0);
      f_up = 1'($urandom_range(1)); f_din = 16'($urandom);
      ew = model_evt(mw, 2, w_rst, w_load, w_en, w_up);
      mw = model_next(mw, 2, 1'b1, w_rst, 25, w_load, clamp_din(w_din, 2), w_en, w_up);
      es = model_evt(ms, 2, s_rst, s_load, s_en, s_up);
      ms = model_next(ms, 2, 1'b0, s_rst, 25, s_load, clamp_din(s_din, 2), s_en, s_up);
      ef = model_evt(mf, 4, f_rst, f_load, f_en, f_up);
      mf = model_next(mf, 4, 1'b1, f_rst, 0, f_load, clamp_din(f_din, 4), f_en, f_up);
      tick();
      exp = int2bcd(mw, 2);
      check_cnt++; if (w_q !== exp[7:0] || w_evt !== ew || w_zero !== (mw == 0) || w_tc !== (w_up ? (mw == 99) : (mw == 0)) || !valid_bcd({8'h00, w_q}, 2))
        $display("[TB] FAIL rand_w cycle %0d got q=%h evt=%b tc=%b zero=%b want q=%h evt=%b", k, w_q, w_evt, w_tc, w_zero, exp[7:0], ew); else pass_cnt++;
      exp = int2bcd(ms, 2);
      check_cnt++; if (s_q !== exp[7:0] || s_evt !== es || s_zero !== (ms == 0) || s_tc !== (s_up ? (ms == 99) : (ms == 0)) || !valid_bcd({8'h00, s_q}, 2))
        $display("[TB] FAIL rand_s cycle %0d got q=%h evt=%b tc=%b zero=%b want q=%h evt=%b", k, s_q, s_evt, s_tc, s_zero, exp[7:0], es); else pass_cnt++;
      exp = int2bcd(mf, 4);
      check_cnt++; if (f_q !== exp || f_evt !== ef || f_zero !== (mf == 0) || f_tc !== (f_up ? (mf == 9999) : (mf == 0)) || !valid_bcd(f_q, 4))
        $display("[TB] FAIL rand_f cycle %0d got q=%h evt=%b tc=%b zero=%b want q=%h evt=%b", k, f_q, f_evt, f_tc, f_zero, exp, ef); else pass_cnt++;
    end
  endtask

  initial begin
    w_rst = 1; w_en = 0; w_up = 0; w_load = 0; w_din = '0;
    s_rst = 1; s_en = 0; s_up = 0; s_load = 0; s_din = '0;
    f_rst = 1; f_en = 0; f_up = 0; f_load = 0; f_din = '0;
    test_reset();
    test_borrow_wrap();
    test_saturate();
    test_load_priority();
    test_reset_mid_count();
    test_four_digit();
    test_random(400);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
